fifo_prog: RTL
==============

// Module: fifo_prog
// PURPOSE
//  Synchronous single-clock FIFO, next generation of the DRAM-cache request/response queue.
//  Adds arbitrary (non-power-of-2) depth, runtime-programmable almost-full/almost-empty thresholds,
//  synchronous flush, and sticky overflow/underflow error flags. Read data is first-word-fall-through.
//  Sits between the cache controller and DRAM command/data paths.
// PARAMETERS
//  DATA_WIDTH  8  width of one entry in bits
//  FIFO_SIZE   8  number of entries; any value >= 2
//  CNT_W       $clog2(FIFO_SIZE+1)  occupancy/threshold width (localparam, derived)
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous active-low reset
//  flush_i       in   1           synchronous flush: discard all entries
//  write_en_i    in   1           write request
//  write_data_i  in   DATA_WIDTH  write data
//  read_en_i     in   1           read request (pops the head entry)
//  read_data_o   out  DATA_WIDTH  head entry, combinational from memory
//  full_o        out  1           occupancy == FIFO_SIZE
//  A_full_o      out  1           occupancy >= afull_thr_i
//  empty_o       out  1           occupancy == 0
//  A_empty_o     out  1           occupancy <= aempty_thr_i
//  afull_thr_i   in   CNT_W       almost-full threshold
//  aempty_thr_i  in   CNT_W       almost-empty threshold
//  remain_o      out  CNT_W       current occupancy
//  ovf_o         out  1           sticky: write_en_i while full_o
//  udf_o         out  1           sticky: read_en_i while empty_o
//  err_clr_i     in   1           clears ovf_o and udf_o
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, remain_o=0, full_o=0, A_full_o=0,
//    empty_o=1, A_empty_o=1, ovf_o=0, udf_o=0. Memory is not reset.
//  - Accepted write: write_en_i & !full_o. Accepted read: read_en_i & !empty_o.
//  - Flags are registered from next occupancy: they reflect state after the edge, with no lag.
//  - Write is visible on read_data_o the cycle after acceptance. read_data_o is don't-care while empty_o.
//  - Pointers wrap from FIFO_SIZE-1 to 0. Wrap must be correct for non-power-of-2 depth.
//  - Simultaneous accepted read and write: occupancy unchanged, both pointers advance.
//  - Full with read+write: only the read is accepted, occupancy -1, and ovf_o sets.
//  - Empty with read+write: only the write is accepted, occupancy +1, and udf_o sets.
//  - flush_i beats read and write: next cycle pointers=0, remain_o=0, empty_o=1, full_o=0.
//    A_* flags are recomputed against 0. A write in the flush cycle is dropped; error flags are not set by it.
//  - Thresholds are sampled every cycle, so a change takes effect at the next edge.
//    afull_thr_i=0 forces A_full_o=1. aempty_thr_i>=FIFO_SIZE forces A_empty_o=1.
//  - ovf_o/udf_o: set wins over err_clr_i in the same cycle. Flags are unaffected by flush_i.
// CONFIGURATION
//  - FIFO_PROG_STATS_EN defined: adds port peak_o (out, CNT_W), the high-watermark of occupancy.
//    peak_o <= max(peak_o, next occupancy). It is cleared to 0 by reset or err_clr_i (clear, then max,
//    in the same cycle) and is not cleared by flush_i.
//  - Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package fifo_pkg: fifo_err_t struct {ovf, udf}, default width/depth constants,
//    and function cnt_w(depth) = $clog2(depth+1).
//  - One sub-module, fifo_ptr: modulo-FIFO_SIZE pointer with inc_i and clr_i.
//    Instantiated twice, for head and tail.
// TESTING (bench with FIFO_SIZE=6, DATA_WIDTH=8, thresholds 4/1)
//  - Write 0x10..0x15 -> full_o=1 after 6th edge, remain_o=6, A_full_o from 4th. Read back 0x10..0x15 in order.
//  - Fill and drain twice (12 wr/rd) -> pointers wrap at 5->0, data order intact, empty_o=1, remain_o=0.
//  - Full, assert read+write(0xAA) -> remain_o=5, ovf_o=1. Then err_clr_i -> ovf_o=0 next cycle.
//  - Empty, assert read+write(0x55) -> remain_o=1, read_data_o=0x55, udf_o=1.
//  - remain_o=3, assert flush_i with write_en_i -> remain_o=0, empty_o=1, A_empty_o=1, no ovf_o/udf_o.
//    Also assert rst_n low mid-burst -> outputs at reset values immediately.
//  - With FIFO_PROG_STATS_EN: fill to 5, drain to 0 -> peak_o=5. err_clr_i -> peak_o=0.

Source files
------------

// File: rtl/fifo_prog_pkg.sv
// Shared types and constants for the programmable-threshold FIFO.
package fifo_pkg;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_SIZE  = 8;

  // Width able to hold every occupancy value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_prog_ptr.sv
// Modulo-DEPTH pointer; wraps from DEPTH-1 to 0 so any depth >= 2 works.
module fifo_ptr #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FWFT FIFO with arbitrary depth, programmable almost flags, flush and sticky errors.
// Optional high-watermark port peak_o is built when FIFO_PROG_STATS_EN is defined.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
  localparam int CNT_W     = cnt_w(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  write_en_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  read_en_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  full_o,
  output logic                  A_full_o,
  output logic                  empty_o,
  output logic                  A_empty_o,
  input  logic [CNT_W-1:0]      afull_thr_i,
  input  logic [CNT_W-1:0]      aempty_thr_i,
  output logic [CNT_W-1:0]      remain_o,
  output logic                  ovf_o,
  output logic                  udf_o,
`ifdef FIFO_PROG_STATS_EN
  output logic [CNT_W-1:0]      peak_o,
`endif
  input  logic                  err_clr_i
);

  localparam int PTR_W = $clog2(FIFO_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_SIZE];
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_full, r_afull, r_empty, r_aempty;
  fifo_err_t             r_err;
  logic [PTR_W-1:0]      w_head, w_tail;
  logic                  w_wr_acc, w_rd_acc;
  logic [CNT_W-1:0]      w_cnt_nxt;
  fifo_err_t             w_err_set;

  // Flush overrides both ports, so nothing is accepted and no error is raised in that cycle.
  assign w_wr_acc    = write_en_i & ~r_full  & ~flush_i;
  assign w_rd_acc    = read_en_i  & ~r_empty & ~flush_i;
  assign w_err_set.ovf = write_en_i & r_full  & ~flush_i;
  assign w_err_set.udf = read_en_i  & r_empty & ~flush_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush_i) begin
      w_cnt_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  fifo_ptr #(.DEPTH(FIFO_SIZE)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_rd_acc),
    .clr_i (flush_i),
    .ptr_o (w_head)
  );

  fifo_ptr #(.DEPTH(FIFO_SIZE)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_wr_acc),
    .clr_i (flush_i),
    .ptr_o (w_tail)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_tail] <= write_data_i;
    end
  end

  // Flags come from the next occupancy so they never lag the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_err    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CNT_W'(FIFO_SIZE));
      r_afull  <= (w_cnt_nxt >= afull_thr_i);
      r_empty  <= (w_cnt_nxt == '0);
      r_aempty <= (w_cnt_nxt <= aempty_thr_i);
      r_err.ovf <= w_err_set.ovf | (r_err.ovf & ~err_clr_i);
      r_err.udf <= w_err_set.udf | (r_err.udf & ~err_clr_i);
    end
  end

`ifdef FIFO_PROG_STATS_EN
  logic [CNT_W-1:0] r_peak;
  logic [CNT_W-1:0] w_peak_base;

  assign w_peak_base = err_clr_i ? '0 : r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else begin
      r_peak <= (w_cnt_nxt > w_peak_base) ? w_cnt_nxt : w_peak_base;
    end
  end

  assign peak_o = r_peak;
`endif

  assign read_data_o = r_mem[w_head];
  assign remain_o    = r_cnt;
  assign full_o      = r_full;
  assign A_full_o    = r_afull;
  assign empty_o     = r_empty;
  assign A_empty_o   = r_aempty;
  assign ovf_o       = r_err.ovf;
  assign udf_o       = r_err.udf;

endmodule
